// File: rtl/clic_claim_decoder_pkg.sv
// clic_claim_decoder_pkg
//   Shared types and sizing for the CLIC claim path. The encoder emits a
//   winning {id, level} pair (clic_enc_t). The claim decoder stores claimed
//   pairs as clic_entry_t on its nesting stack.
//   Sizing: NUM_INT sources, ID_W id bits, LEVEL_W level bits and DEPTH
//   nesting entries. A level of LEVEL_NONE (0) means "no interrupt".
package clic_claim_decoder_pkg;

  localparam int NUM_INT = 16;
  localparam int ID_W    = $clog2(NUM_INT);
  localparam int LEVEL_W = 8;
  localparam int DEPTH   = 4;
  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [LEVEL_W-1:0] LEVEL_NONE = '0;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [LEVEL_W-1:0] level;
  } clic_entry_t;

  // The encoder output pair has the same shape as a stack entry.
  typedef clic_entry_t clic_enc_t;

  typedef enum logic {
    ST_IDLE,
    ST_OFFER
  } state_t;

  // One-hot decode of an interrupt id.
  function automatic logic [NUM_INT-1:0] id_onehot(input logic [ID_W-1:0] id);
    return {{(NUM_INT-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/clic_claim_decoder_if.sv
// clic_claim_decoder_if
//   Bundles the encoder input, the core claim/complete handshake and the
//   status outputs of the claim decoder.
//   master : the claim decoder. It receives enc_* and claim/complete, and it
//            drives irq_*, clr_pend, in_service, cur_level, depth and err.
//   slave  : the encoder/core side, in the opposite directions.
interface clic_claim_decoder_if;
  import clic_claim_decoder_pkg::*;

  logic                 enc_valid;
  logic [ID_W-1:0]      enc_id;
  logic [LEVEL_W-1:0]   enc_level;
  logic                 irq_req;
  logic [ID_W-1:0]      irq_id;
  logic [LEVEL_W-1:0]   irq_level;
  logic                 irq_claim;
  logic                 irq_complete;
  logic [ID_W-1:0]      cmpl_id;
  logic [NUM_INT-1:0]   clr_pend;
  logic [NUM_INT-1:0]   in_service;
  logic [LEVEL_W-1:0]   cur_level;
  logic [DEPTH_W-1:0]   depth;
  logic                 err;

  modport master (
    input  enc_valid, enc_id, enc_level, irq_claim, irq_complete, cmpl_id,
    output irq_req, irq_id, irq_level, clr_pend, in_service, cur_level,
           depth, err
  );

  modport slave (
    output enc_valid, enc_id, enc_level, irq_claim, irq_complete, cmpl_id,
    input  irq_req, irq_id, irq_level, clr_pend, in_service, cur_level,
           depth, err
  );
endinterface

// File: rtl/clic_nest_stack.sv
// clic_nest_stack
//   A DEPTH-entry LIFO of active interrupts, as {id, level} pairs.
//   clk, rst   : clock and synchronous active-high reset (the stack is
//                emptied on reset).
//   push       : push push_entry onto the stack.
//   pop        : remove the top entry. When push and pop happen in the
//                same cycle, the pop is applied first, so the pushed entry
//                replaces the old top.
//   top        : the top entry, or all zeros when the stack is empty.
//   depth      : the number of stored entries.
//   in_service : the OR of the one-hot ids of all stored entries.
//   The caller never pushes onto a full stack unless it also pops, and it
//   never pops an empty stack.
module clic_nest_stack
  import clic_claim_decoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  clic_entry_t        push_entry,
  output clic_entry_t        top,
  output logic [DEPTH_W-1:0] depth,
  output logic [NUM_INT-1:0] in_service
);

  clic_entry_t        entries_reg [DEPTH];
  logic [DEPTH_W-1:0] depth_reg;
  logic [DEPTH_W-1:0] depth_next;
  logic [PTR_W-1:0]   top_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  always_comb begin
    top_ptr = PTR_W'(depth_reg - DEPTH_W'(1));
    wr_ptr  = pop ? top_ptr : PTR_W'(depth_reg);
    depth_next = depth_reg;
    case ({push, pop})
      2'b10:   depth_next = depth_reg + DEPTH_W'(1);
      2'b01:   depth_next = depth_reg - DEPTH_W'(1);
      default: depth_next = depth_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_reg <= '0;
    end else begin
      depth_reg <= depth_next;
    end
  end

  // Entry storage needs no reset. Entries above depth_reg are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_reg[wr_ptr] <= push_entry;
    end
  end

  assign top   = (depth_reg == '0) ? '0 : entries_reg[top_ptr];
  assign depth = depth_reg;

  // in_service is built as an OR chain over the live entries.
  logic [NUM_INT-1:0] or_chain [DEPTH+1];
  assign or_chain[0] = '0;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_svc
    assign or_chain[gi+1] = or_chain[gi] |
        ((DEPTH_W'(gi) < depth_reg) ? id_onehot(entries_reg[gi].id) : '0);
  end

  assign in_service = or_chain[DEPTH];

endmodule

// File: rtl/clic_claim_decoder.sv
// clic_claim_decoder
//   Turns the pending-interrupt encoder winner into a core interrupt
//   request and runs the claim/complete handshake. The module has these
//   parts:
//   - An offer FSM (IDLE/OFFER). Only a level strictly above the current
//     nesting level is offered.
//   - A one-hot pending-clear pulse, issued when an offer is claimed.
//   - Error pulses for a claim made with no offer and for a bad complete.
//   - A nesting stack (clic_nest_stack).
//   Ports:
//   clk, rst : clock and synchronous active-high reset.
//   bus      : clic_claim_decoder_if.master. It carries the encoder input,
//              the core handshake and the status outputs.
module clic_claim_decoder
  import clic_claim_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  clic_claim_decoder_if.master bus
);

  state_t             state_reg, state_next;
  clic_enc_t          offer_reg, offer_next;
  logic               irq_req_reg, irq_req_next;
  logic [NUM_INT-1:0] clr_pend_reg, clr_pend_next;
  logic               err_reg, err_next;

  clic_enc_t          enc;
  clic_entry_t        top;
  logic [DEPTH_W-1:0] depth_w;
  logic [NUM_INT-1:0] in_service_w;
  logic [NUM_INT-1:0] offer_dec;

  logic elig;
  logic cmpl_hit;
  logic claim_ok;

  assign enc = '{id: bus.enc_id, level: bus.enc_level};

  // Decode the latched offer id, which is the id that a claim clears.
  for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_dec
    assign offer_dec[gi] = (offer_reg.id == ID_W'(gi));
  end

  always_comb begin
    // An empty stack reports top = 0, so cur_level is LEVEL_NONE.
    elig = bus.enc_valid && (enc.level != LEVEL_NONE) &&
           (enc.level > top.level) && (depth_w < DEPTH_W'(DEPTH));
    cmpl_hit = bus.irq_complete && (depth_w != '0) && (bus.cmpl_id == top.id);
    claim_ok = (state_reg == ST_OFFER) && bus.irq_claim;

    state_next    = state_reg;
    offer_next    = offer_reg;
    clr_pend_next = '0;
    err_next      = (bus.irq_complete && !cmpl_hit) ||
                    ((state_reg == ST_IDLE) && bus.irq_claim);

    case (state_reg)
      ST_IDLE: begin
        if (elig) begin
          state_next = ST_OFFER;
          offer_next = enc;
        end
      end
      ST_OFFER: begin
        if (bus.irq_claim) begin
          // A claim takes the latched offer, not the current enc_* value.
          state_next    = ST_IDLE;
          clr_pend_next = offer_dec;
        end else if (!elig) begin
          state_next = ST_IDLE;
        end else if (enc.level > offer_reg.level) begin
          offer_next = enc;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    irq_req_next = (state_next == ST_OFFER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      offer_reg    <= '0;
      irq_req_reg  <= 1'b0;
      clr_pend_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      offer_reg    <= offer_next;
      irq_req_reg  <= irq_req_next;
      clr_pend_reg <= clr_pend_next;
      err_reg      <= err_next;
    end
  end

  // The stack applies a pop before a push in the same cycle, so a complete
  // is checked against the top entry as it was before this cycle.
  clic_nest_stack u_stack (
    .clk        (clk),
    .rst        (rst),
    .push       (claim_ok),
    .pop        (cmpl_hit),
    .push_entry (offer_reg),
    .top        (top),
    .depth      (depth_w),
    .in_service (in_service_w)
  );

  assign bus.irq_req    = irq_req_reg;
  assign bus.irq_id     = offer_reg.id;
  assign bus.irq_level  = offer_reg.level;
  assign bus.clr_pend   = clr_pend_reg;
  assign bus.in_service = in_service_w;
  assign bus.cur_level  = top.level;
  assign bus.depth      = depth_w;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_clic_claim_decoder.sv
// tb_clic_claim_decoder
//   Directed scenarios followed by randomized traffic. All traffic is
//   checked every cycle against a behavioural model. The model keeps the
//   nesting stack as queues and the current offer as plain variables.
module tb_clic_claim_decoder;
  import clic_claim_decoder_pkg::*;

  logic clk;
  logic rst;

  clic_claim_decoder_if bus();

  clic_claim_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int cyc;

  // Reference model state.
  int m_id[$];
  int m_lvl[$];
  bit m_off;
  int m_oid;
  int m_olvl;
  int m_clr;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_step(input bit r, input bit v, input int id, input int lvl,
                                     input bit clm, input bit cmp, input int cid);
    int  cur;
    int  d;
    bit  elig;
    bit  do_pop;
    bit  do_push;
    int  p_id;
    int  p_lvl;
    if (r) begin
      m_id.delete();
      m_lvl.delete();
      m_off = 0; m_oid = 0; m_olvl = 0; m_clr = 0; m_err = 0;
      return;
    end
    d    = m_id.size();
    cur  = (d == 0) ? 0 : m_lvl[d-1];
    elig = v && (lvl != 0) && (lvl > cur) && (d < DEPTH);
    m_clr = 0;
    m_err = 0;
    do_pop = 0;
    do_push = 0;
    p_id = m_oid;
    p_lvl = m_olvl;
    if (cmp) begin
      if (d > 0 && cid == m_id[d-1]) do_pop = 1;
      else m_err = 1;
    end
    if (!m_off) begin
      if (clm) m_err = 1;
      if (elig) begin
        m_off = 1; m_oid = id; m_olvl = lvl;
      end
    end else if (clm) begin
      do_push = 1;
      m_clr = 1 << m_oid;
      m_off = 0;
    end else if (!elig) begin
      m_off = 0;
    end else if (lvl > m_olvl) begin
      m_oid = id; m_olvl = lvl;
    end
    if (do_pop) begin
      void'(m_id.pop_back());
      void'(m_lvl.pop_back());
    end
    if (do_push) begin
      m_id.push_back(p_id);
      m_lvl.push_back(p_lvl);
    end
  endfunction

  // One clock cycle. Drive the inputs, advance the model, then compare
  // every output just after the clock edge.
  task automatic cycle(input bit r, input bit v, input int id, input int lvl,
                       input bit clm, input bit cmp, input int cid);
    int svc;
    int d;
    rst              = r;
    bus.enc_valid    = v;
    bus.enc_id       = id[ID_W-1:0];
    bus.enc_level    = lvl[LEVEL_W-1:0];
    bus.irq_claim    = clm;
    bus.irq_complete = cmp;
    bus.cmpl_id      = cid[ID_W-1:0];
    model_step(r, v, id, lvl, clm, cmp, cid);
    @(posedge clk);
    #1;
    cyc++;
    svc = 0;
    foreach (m_id[k]) svc |= (1 << m_id[k]);
    d = m_id.size();
    check("irq_req",    32'(bus.irq_req),    32'(m_off));
    check("irq_id",     32'(bus.irq_id),     32'(m_oid));
    check("irq_level",  32'(bus.irq_level),  32'(m_olvl));
    check("clr_pend",   32'(bus.clr_pend),   32'(m_clr));
    check("in_service", 32'(bus.in_service), 32'(svc));
    check("cur_level",  32'(bus.cur_level),  (d == 0) ? 32'd0 : 32'(m_lvl[d-1]));
    check("depth",      32'(bus.depth),      32'(d));
    check("err",        32'(bus.err),        32'(m_err));
    $display("[TB] cyc=%0d rst=%0d v=%0d enc=%0d/%0d clm=%0d cmp=%0d(%0d) -> req=%0d id=%0d lvl=%0d clr=%h svc=%h cur=%0d dep=%0d err=%0d",
             cyc, r, v, id, lvl, clm, cmp, cid, bus.irq_req, bus.irq_id, bus.irq_level,
             bus.clr_pend, bus.in_service, bus.cur_level, bus.depth, bus.err);
  endtask

  initial begin
    bit v;
    bit clm;
    bit cmp;
    bit r;
    int id;
    int lvl;
    int cid;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    clk     = 1'b0;
    m_off = 0; m_oid = 0; m_olvl = 0; m_clr = 0; m_err = 0;

    // Reset state.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("rst_req", 32'(bus.irq_req), 32'd0);
    check("rst_depth", 32'(bus.depth), 32'd0);

    // Basic claim of id 5 at level 3.
    cycle(0, 1, 5, 3, 0, 0, 0);
    check("basic_req", 32'(bus.irq_req), 32'd1);
    check("basic_id", 32'(bus.irq_id), 32'd5);
    cycle(0, 1, 5, 3, 1, 0, 0);
    check("basic_clr", 32'(bus.clr_pend), 32'h0020);
    check("basic_svc", 32'(bus.in_service), 32'h0020);
    cycle(0, 1, 5, 3, 0, 0, 0);
    check("basic_clr_once", 32'(bus.clr_pend), 32'h0);
    check("basic_nopreempt", 32'(bus.irq_req), 32'd0);
    // Preempt with id 2 at level 7, then complete it.
    cycle(0, 1, 2, 7, 0, 0, 0);
    cycle(0, 1, 2, 7, 1, 0, 0);
    check("pre_svc", 32'(bus.in_service), 32'h0024);
    check("pre_cur", 32'(bus.cur_level), 32'd7);
    cycle(0, 0, 0, 0, 0, 1, 2);
    check("pre_back", 32'(bus.cur_level), 32'd3);
    // Complete with a wrong id: no pop and an err pulse.
    cycle(0, 0, 0, 0, 0, 1, 6);
    check("bad_cmpl_err", 32'(bus.err), 32'd1);
    check("bad_cmpl_depth", 32'(bus.depth), 32'd1);
    cycle(0, 0, 0, 0, 0, 1, 5);
    // Complete on an empty stack, then a claim in IDLE.
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("empty_cmpl_err", 32'(bus.err), 32'd1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("idle_claim_err", 32'(bus.err), 32'd1);

    // Offer replacement, then withdrawal.
    cycle(0, 1, 1, 4, 0, 0, 0);
    cycle(0, 1, 9, 6, 0, 0, 0);
    check("replace_id", 32'(bus.irq_id), 32'd9);
    cycle(0, 0, 9, 6, 0, 0, 0);
    check("withdraw", 32'(bus.irq_req), 32'd0);

    // Fill the stack, then check that a full stack blocks new offers.
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(0, 1, k, k, 0, 0, 0);
      cycle(0, 1, k, k, 1, 0, 0);
    end
    cycle(0, 1, 9, 9, 0, 0, 0);
    check("full_block", 32'(bus.irq_req), 32'd0);
    cycle(0, 1, 9, 9, 0, 1, DEPTH);
    cycle(0, 1, 9, 9, 0, 0, 0);
    check("full_reoffer", 32'(bus.irq_req), 32'd1);

    // Claim and complete in the same cycle.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 5, 3, 0, 0, 0);
    cycle(0, 1, 5, 3, 1, 0, 0);
    cycle(0, 1, 2, 7, 0, 0, 0);
    cycle(0, 1, 2, 7, 1, 1, 5);
    check("simul_depth", 32'(bus.depth), 32'd1);
    check("simul_svc", 32'(bus.in_service), 32'h0004);
    check("simul_clr", 32'(bus.clr_pend), 32'h0004);
    // Assert reset while an offer is pending.
    cycle(0, 1, 3, 9, 0, 0, 0);
    cycle(1, 1, 3, 9, 0, 0, 0);
    check("rst_offer_req", 32'(bus.irq_req), 32'd0);
    check("rst_offer_svc", 32'(bus.in_service), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 9) < 7);
      id  = $urandom_range(0, NUM_INT - 1);
      lvl = $urandom_range(0, 12);
      clm = m_off ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      cmp = ($urandom_range(0, 4) == 0);
      cid = (m_id.size() > 0 && $urandom_range(0, 3) != 0) ? m_id[m_id.size()-1]
                                                          : $urandom_range(0, NUM_INT - 1);
      cycle(r, v, id, lvl, clm, cmp, cid);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
